arp_cache: RTL and testbench
============================

Name: arp_cache

Overview:
- IP→MAC resolution table sitting directly beside the IP TX stage.
- Consumes the IP layer's next-hop lookup request (seek IP) and returns the destination MAC (seek MAC) with fixed latency.
- Learns bindings from the ARP receive path.
- On a miss, returns a broadcast MAC and issues one ARP request towards the ARP transmit path.

Parameters:
- P_DEPTH, 8: number of table entries; power of two, 2..32.
- P_MISS_MAC, 48'hFF_FF_FF_FF_FF_FF: MAC returned on a lookup miss.
- P_AGE_CYCLES, 32'd156_250_000: prescaler period in clock cycles; used only with ARP_CACHE_AGING_EN.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-low.
- i_seek_ip  in  32  lookup IP.
- i_seek_ip_valid  in  1  lookup strobe; one lookup per cycle max.
- o_seek_mac  out  48  resolved MAC.
- o_seek_mac_valid  out  1  one-cycle result strobe.
- o_seek_hit  out  1  1 = entry found, 0 = miss; qualified by o_seek_mac_valid.
- i_learn_ip  in  32  IP from received ARP packet.
- i_learn_mac  in  48  MAC from received ARP packet.
- i_learn_valid  in  1  learn strobe.
- o_arp_req_ip  out  32  IP to resolve.
- o_arp_req_valid  out  1  ARP request valid.
- i_arp_req_ready  in  1  ARP TX accepts request.
- o_entry_cnt  out  6  number of valid entries.

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - All entry valid bits cleared.
  - Replacement pointer = 0.
  - Lookup pipeline flushed.
  - Pending ARP request dropped.
  - o_seek_mac = 0; o_seek_mac_valid, o_seek_hit, o_arp_req_valid = 0; o_arp_req_ip = 0; o_entry_cnt = 0.
  - Reset asserted mid-lookup: no result strobe emitted for the in-flight lookup.
- Table: P_DEPTH entries of {valid, ip[31:0], mac[47:0]} in registers.
- Lookup:
  - Stage 1 (edge N): i_seek_ip registered.
  - Stage 2 (edge N+1): registered IP compared in parallel against all valid entries; hit flag and index registered.
  - Edge N+2: o_seek_mac_valid pulses for one cycle. o_seek_mac = the entry's MAC on a hit, P_MISS_MAC on a miss.
  - Latency is exactly 2 cycles. Fully pipelined; back-to-back requests give back-to-back results in order.
  - A lookup sees the table as it stands at the stage-2 compare edge. A learn strobed in the same cycle as stage 2 is not visible; a learn one cycle earlier is.
- Learn:
  - i_learn_ip == 0.0.0.0 or 255.255.255.255 is ignored.
  - IP already present: MAC updated in place; pointer and count unchanged.
  - IP not present and a free entry exists: write the lowest-index invalid entry.
  - Table full: overwrite the entry at the replacement pointer, then pointer+1, wrapping at P_DEPTH-1→0.
  - o_entry_cnt is updated one cycle after the learn; saturates at P_DEPTH.
- ARP request (valid/ready):
  - On a miss result with no request pending: o_arp_req_valid=1 and o_arp_req_ip = missed IP from the next cycle.
  - The request is held stable until i_arp_req_ready=1; it clears on that edge.
  - Misses while a request is pending are dropped; the IP layer retries.
  - A learn matching the pending IP does not cancel an already-raised request.
- Simultaneous learn + lookup of different IPs: both proceed independently.

Optional Feature:
ARP_CACHE_AGING_EN
- Defined:
  - A global prescaler counts 0..P_AGE_CYCLES-1 and emits a tick on wrap.
  - Each entry has a 4-bit age, incremented on each tick and saturating.
  - Age is cleared on learn write or update.
  - An entry whose age reaches 15 is invalidated on the next cycle, and o_entry_cnt is decremented.
  - A tick coinciding with a learn of that entry leaves age 0 and the entry valid.
- Undefined: no prescaler or age logic; entries persist until overwritten or reset.

Test Plan:
- Reset, then lookup 192.168.100.100 → at N+2: o_seek_mac_valid=1, hit=0, mac=FF:FF:FF:FF:FF:FF; o_arp_req_valid=1 with ip C0A86464, held until ready; ready pulse → valid=0.
- Learn C0A86464→00:11:22:33:44:55, then lookup 2 cycles later → hit=1, mac=001122334455, o_entry_cnt=1, no ARP request.
- Learn same IP with 66:77:88:99:AA:BB → lookup returns new MAC; o_entry_cnt stays 1.
- P_DEPTH=8: learn 9 distinct IPs .1–.9 → count=8; .1 evicted (miss), .9 and .2 hit; pointer=1 afterwards.
- Back-to-back lookups hit/miss/hit on 3 consecutive cycles → 3 consecutive result strobes in order; a second miss while a request is pending leaves o_arp_req_ip unchanged.
- With ARP_CACHE_AGING_EN and P_AGE_CYCLES=4: learn one entry, idle 64+ cycles → lookup misses and o_entry_cnt=0. Assert reset mid-lookup → no result strobe, all outputs 0.

Source files
------------

// File: rtl/arp_cache.sv
// IP->MAC resolution cache: 2-cycle pipelined lookup, ARP-learned entries, miss-driven ARP requests.
// Optional entry aging is compiled in with `define ARP_CACHE_AGING_EN.
module arp_cache #(
    parameter int          P_DEPTH      = 8,
    parameter logic [47:0] P_MISS_MAC   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [31:0] P_AGE_CYCLES = 32'd156_250_000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_seek_ip,
    input  logic        i_seek_ip_valid,
    output logic [47:0] o_seek_mac,
    output logic        o_seek_mac_valid,
    output logic        o_seek_hit,
    input  logic [31:0] i_learn_ip,
    input  logic [47:0] i_learn_mac,
    input  logic        i_learn_valid,
    output logic [31:0] o_arp_req_ip,
    output logic        o_arp_req_valid,
    input  logic        i_arp_req_ready,
    output logic [5:0]  o_entry_cnt
);
    localparam int IW = $clog2(P_DEPTH);

    typedef struct packed {
        logic        vld;
        logic [31:0] ip;
        logic [47:0] mac;
    } entry_t;

    entry_t [P_DEPTH-1:0] tbl, tbl_nxt;
    logic [IW-1:0]        rep_ptr, rep_ptr_nxt;
    logic [P_DEPTH-1:0]   seek_match, learn_match;
    logic [47:0]          seek_mac;
    logic                 learn_ok, free_found;
    logic [IW-1:0]        free_idx;
    logic [5:0]           cnt_nxt;

    logic [2:0]  vld_pipe;
    logic [31:0] s1_ip, s2_ip;
    logic        s2_hit;
    logic [47:0] s2_mac;

    for (genvar g = 0; g < P_DEPTH; g++) begin : g_cmp
        assign seek_match[g]  = tbl[g].vld && (tbl[g].ip == s1_ip);
        assign learn_match[g] = tbl[g].vld && (tbl[g].ip == i_learn_ip);
    end

    always_comb begin
        seek_mac = '0;
        for (int i = 0; i < P_DEPTH; i++)
            if (seek_match[i]) seek_mac |= tbl[i].mac;
    end

    always_comb begin
        learn_ok   = i_learn_valid && (i_learn_ip != 32'h0) && (i_learn_ip != 32'hFFFF_FFFF);
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = P_DEPTH - 1; i >= 0; i--)
            if (!tbl[i].vld) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
    end

`ifdef ARP_CACHE_AGING_EN
    logic [31:0]              pre_cnt;
    logic                     age_tick;
    logic [P_DEPTH-1:0][3:0]  age;
    logic [P_DEPTH-1:0]       wr;

    assign age_tick = (pre_cnt == P_AGE_CYCLES - 32'd1);

    always_comb begin
        wr = '0;
        if (learn_ok) begin
            if (|learn_match)    wr = learn_match;
            else if (free_found) wr[free_idx] = 1'b1;
            else                 wr[rep_ptr] = 1'b1;
        end
    end

    // A learn write always wins over a coincident tick, so a refreshed entry restarts at 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pre_cnt <= '0;
            age     <= '0;
        end else begin
            pre_cnt <= age_tick ? '0 : pre_cnt + 32'd1;
            for (int i = 0; i < P_DEPTH; i++) begin
                if (wr[i] || !tbl_nxt[i].vld)           age[i] <= '0;
                else if (age_tick && age[i] != 4'hF)    age[i] <= age[i] + 4'd1;
            end
        end
    end
`endif

    always_comb begin
        tbl_nxt     = tbl;
        rep_ptr_nxt = rep_ptr;
        if (learn_ok) begin
            if (|learn_match) begin
                for (int i = 0; i < P_DEPTH; i++)
                    if (learn_match[i]) tbl_nxt[i].mac = i_learn_mac;
            end else if (free_found) begin
                tbl_nxt[free_idx] = {1'b1, i_learn_ip, i_learn_mac};
            end else begin
                tbl_nxt[rep_ptr] = {1'b1, i_learn_ip, i_learn_mac};
                rep_ptr_nxt      = rep_ptr + IW'(1);
            end
        end
`ifdef ARP_CACHE_AGING_EN
        for (int i = 0; i < P_DEPTH; i++)
            if (tbl[i].vld && age[i] == 4'hF && !wr[i]) tbl_nxt[i].vld = 1'b0;
`endif
        cnt_nxt = '0;
        for (int i = 0; i < P_DEPTH; i++)
            if (tbl_nxt[i].vld) cnt_nxt = cnt_nxt + 6'd1;
    end

    assign o_seek_mac_valid = vld_pipe[2];

    // Stage 2 captures the MAC itself, so a learn landing between compare and output cannot leak in.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            tbl             <= '0;
            rep_ptr         <= '0;
            o_entry_cnt     <= '0;
            vld_pipe        <= '0;
            s1_ip           <= '0;
            s2_ip           <= '0;
            s2_hit          <= 1'b0;
            s2_mac          <= '0;
            o_seek_mac      <= '0;
            o_seek_hit      <= 1'b0;
            o_arp_req_valid <= 1'b0;
            o_arp_req_ip    <= '0;
        end else begin
            tbl         <= tbl_nxt;
            rep_ptr     <= rep_ptr_nxt;
            o_entry_cnt <= cnt_nxt;
            vld_pipe    <= {vld_pipe[1:0], i_seek_ip_valid};
            s1_ip       <= i_seek_ip;
            s2_ip       <= s1_ip;
            s2_hit      <= |seek_match;
            s2_mac      <= seek_mac;
            if (vld_pipe[1]) begin
                o_seek_hit <= s2_hit;
                o_seek_mac <= s2_hit ? s2_mac : P_MISS_MAC;
            end
            if (o_arp_req_valid) begin
                if (i_arp_req_ready) o_arp_req_valid <= 1'b0;
            end else if (vld_pipe[1] && !s2_hit) begin
                o_arp_req_valid <= 1'b1;
                o_arp_req_ip    <= s2_ip;
            end
        end
    end
endmodule

// File: tb/tb_arp_cache.sv
// Self-checking bench for arp_cache: directed scenarios with literal expectations plus a
// randomized phase compared every cycle against a queue/array reference model.
module tb_arp_cache;
    localparam int DEPTH = 8;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_seek_ip;
    logic        i_seek_ip_valid;
    logic [47:0] o_seek_mac;
    logic        o_seek_mac_valid;
    logic        o_seek_hit;
    logic [31:0] i_learn_ip;
    logic [47:0] i_learn_mac;
    logic        i_learn_valid;
    logic [31:0] o_arp_req_ip;
    logic        o_arp_req_valid;
    logic        i_arp_req_ready;
    logic [5:0]  o_entry_cnt;

    arp_cache #(.P_DEPTH(DEPTH)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_seek_ip(i_seek_ip), .i_seek_ip_valid(i_seek_ip_valid),
        .o_seek_mac(o_seek_mac), .o_seek_mac_valid(o_seek_mac_valid), .o_seek_hit(o_seek_hit),
        .i_learn_ip(i_learn_ip), .i_learn_mac(i_learn_mac), .i_learn_valid(i_learn_valid),
        .o_arp_req_ip(o_arp_req_ip), .o_arp_req_valid(o_arp_req_valid),
        .i_arp_req_ready(i_arp_req_ready), .o_entry_cnt(o_entry_cnt)
    );

    always #5 i_clk = ~i_clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // Reference model: table as plain arrays, lookups/results as timestamped queues.
    typedef struct { logic [31:0] ip; int t; } lk_t;
    typedef struct { logic hit; logic [47:0] mac; logic [31:0] ip; int due; } rs_t;

    logic        m_vld [DEPTH];
    logic [31:0] m_ip  [DEPTH];
    logic [47:0] m_mac [DEPTH];
    int          m_ptr;
    lk_t         lk_q[$];
    rs_t         rs_q[$];
    int          cyc = 0;

    logic        exp_sv = 1'b0, exp_hit = 1'b0, exp_rv = 1'b0;
    logic [47:0] exp_mac = '0;
    logic [31:0] exp_rip = '0;
    logic [5:0]  exp_cnt = '0;

    initial forever begin
        @(posedge i_clk);
        cyc++;
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
            m_ptr = 0;
            lk_q.delete();
            rs_q.delete();
            exp_sv = 0; exp_hit = 0; exp_mac = '0; exp_rv = 0; exp_rip = '0; exp_cnt = '0;
        end else begin
            rs_t r;
            r = '{hit: 1'b1, mac: '0, ip: '0, due: 0};
            exp_sv = 1'b0;
            if (rs_q.size() > 0 && rs_q[0].due == cyc) begin
                r       = rs_q.pop_front();
                exp_sv  = 1'b1;
                exp_hit = r.hit;
                exp_mac = r.hit ? r.mac : 48'hFFFF_FFFF_FFFF;
            end
            if (exp_rv) begin
                if (i_arp_req_ready) exp_rv = 1'b0;
            end else if (exp_sv && !exp_hit) begin
                exp_rv  = 1'b1;
                exp_rip = r.ip;
            end
            // Lookup captured last edge sees the table before this edge's learn.
            if (lk_q.size() > 0 && lk_q[0].t == cyc - 1) begin
                lk_t l;
                rs_t n;
                l = lk_q.pop_front();
                n = '{hit: 1'b0, mac: '0, ip: l.ip, due: cyc + 1};
                for (int i = 0; i < DEPTH; i++)
                    if (m_vld[i] && m_ip[i] == l.ip) begin n.hit = 1'b1; n.mac = m_mac[i]; end
                rs_q.push_back(n);
            end
            if (i_learn_valid && i_learn_ip != 32'h0 && i_learn_ip != 32'hFFFF_FFFF) begin
                int found, free;
                found = -1; free = -1;
                for (int i = 0; i < DEPTH; i++)
                    if (m_vld[i] && m_ip[i] == i_learn_ip) found = i;
                for (int i = DEPTH - 1; i >= 0; i--)
                    if (!m_vld[i]) free = i;
                if (found >= 0) m_mac[found] = i_learn_mac;
                else begin
                    int w;
                    w = (free >= 0) ? free : m_ptr;
                    if (free < 0) m_ptr = (m_ptr + 1) % DEPTH;
                    m_vld[w] = 1'b1; m_ip[w] = i_learn_ip; m_mac[w] = i_learn_mac;
                end
            end
            if (i_seek_ip_valid) lk_q.push_back('{ip: i_seek_ip, t: cyc});
            exp_cnt = '0;
            for (int i = 0; i < DEPTH; i++) if (m_vld[i]) exp_cnt = exp_cnt + 6'd1;
        end
    end

    initial begin
        @(posedge i_clk);
        forever begin
            @(negedge i_clk);
            chk("m_seek_vld", 64'(o_seek_mac_valid), 64'(exp_sv));
            if (exp_sv) begin
                chk("m_seek_hit", 64'(o_seek_hit), 64'(exp_hit));
                chk("m_seek_mac", 64'(o_seek_mac), 64'(exp_mac));
            end
            chk("m_arp_vld", 64'(o_arp_req_valid), 64'(exp_rv));
            if (exp_rv) chk("m_arp_ip", 64'(o_arp_req_ip), 64'(exp_rip));
            chk("m_cnt", 64'(o_entry_cnt), 64'(exp_cnt));
        end
    end

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
        i_learn_ip = ip; i_learn_mac = mac; i_learn_valid = 1'b1;
        tick();
        i_learn_valid = 1'b0;
    endtask

    // Returns on the negedge right after the result edge (capture edge + 2).
    task automatic seek(input logic [31:0] ip, input logic hit, input logic [47:0] mac, input string nm);
        i_seek_ip = ip; i_seek_ip_valid = 1'b1;
        tick();
        i_seek_ip_valid = 1'b0;
        tick();
        tick();
        chk({nm, "_vld"}, 64'(o_seek_mac_valid), 64'd1);
        chk({nm, "_hit"}, 64'(o_seek_hit), 64'(hit));
        chk({nm, "_mac"}, 64'(o_seek_mac), 64'(mac));
    endtask

    localparam logic [47:0] BC = 48'hFFFF_FFFF_FFFF;

    initial begin
        i_rst = 1'b0; i_seek_ip = '0; i_seek_ip_valid = 1'b0;
        i_learn_ip = '0; i_learn_mac = '0; i_learn_valid = 1'b0; i_arp_req_ready = 1'b0;
        tick(); tick();
        chk("rst_mac", 64'(o_seek_mac), 64'd0);
        chk("rst_vld", 64'(o_seek_mac_valid), 64'd0);
        chk("rst_hit", 64'(o_seek_hit), 64'd0);
        chk("rst_arp_vld", 64'(o_arp_req_valid), 64'd0);
        chk("rst_arp_ip", 64'(o_arp_req_ip), 64'd0);
        chk("rst_cnt", 64'(o_entry_cnt), 64'd0);
        i_rst = 1'b1;

        seek(32'hC0A8_6464, 1'b0, BC, "miss1");
        chk("miss1_arp_vld", 64'(o_arp_req_valid), 64'd1);
        chk("miss1_arp_ip", 64'(o_arp_req_ip), 64'hC0A8_6464);
        tick(); tick(); tick();
        chk("hold_arp_vld", 64'(o_arp_req_valid), 64'd1);
        chk("hold_arp_ip", 64'(o_arp_req_ip), 64'hC0A8_6464);
        i_arp_req_ready = 1'b1;
        tick();
        i_arp_req_ready = 1'b0;
        chk("acc_arp_vld", 64'(o_arp_req_valid), 64'd0);

        learn(32'hC0A8_6464, 48'h0011_2233_4455);
        seek(32'hC0A8_6464, 1'b1, 48'h0011_2233_4455, "hit1");
        chk("hit1_cnt", 64'(o_entry_cnt), 64'd1);
        chk("hit1_noarp", 64'(o_arp_req_valid), 64'd0);
        learn(32'hC0A8_6464, 48'h6677_8899_AABB);
        seek(32'hC0A8_6464, 1'b1, 48'h6677_8899_AABB, "upd");
        chk("upd_cnt", 64'(o_entry_cnt), 64'd1);

        i_rst = 1'b0; tick(); i_rst = 1'b1;
        learn(32'h0000_0000, 48'h1);
        learn(32'hFFFF_FFFF, 48'h2);
        tick();
        chk("bad_ip_cnt", 64'(o_entry_cnt), 64'd0);
        for (int i = 1; i <= 9; i++) learn(32'h0A00_0000 + 32'(i), 48'hAA00_0000_0000 + 48'(i));
        tick();
        chk("full_cnt", 64'(o_entry_cnt), 64'd8);
        seek(32'h0A00_0001, 1'b0, BC, "evict1");
        chk("evict1_arp_ip", 64'(o_arp_req_ip), 64'h0A00_0001);
        seek(32'h0A00_0009, 1'b1, 48'hAA00_0000_0009, "new9");
        seek(32'h0A00_0002, 1'b1, 48'hAA00_0000_0002, "keep2");
        learn(32'h0A00_000A, 48'hAA00_0000_000A);
        seek(32'h0A00_0002, 1'b0, BC, "ptr1");
        seek(32'h0A00_0003, 1'b1, 48'hAA00_0000_0003, "keep3");

        i_seek_ip_valid = 1'b1;
        i_seek_ip = 32'h0A00_0009; tick();
        i_seek_ip = 32'h0A00_00FF; tick();
        i_seek_ip = 32'h0A00_0003; tick();
        i_seek_ip_valid = 1'b0;
        chk("b2b0_vld", 64'(o_seek_mac_valid), 64'd1);
        chk("b2b0_mac", 64'(o_seek_mac), 64'hAA00_0000_0009);
        tick();
        chk("b2b1_vld", 64'(o_seek_mac_valid), 64'd1);
        chk("b2b1_hit", 64'(o_seek_hit), 64'd0);
        tick();
        chk("b2b2_vld", 64'(o_seek_mac_valid), 64'd1);
        chk("b2b2_mac", 64'(o_seek_mac), 64'hAA00_0000_0003);
        chk("b2b_arp_ip", 64'(o_arp_req_ip), 64'h0A00_0001);

        for (int k = 0; k < 3000; k++) begin
            i_rst           = ($urandom_range(0, 499) != 0);
            i_seek_ip_valid = $urandom_range(0, 1);
            i_seek_ip       = ($urandom_range(0, 9) == 0) ? $urandom()
                                                          : 32'h0A00_0000 + 32'($urandom_range(0, 13));
            i_learn_valid   = ($urandom_range(0, 9) < 3);
            case ($urandom_range(0, 19))
                0:       i_learn_ip = 32'h0;
                1:       i_learn_ip = 32'hFFFF_FFFF;
                default: i_learn_ip = 32'h0A00_0000 + 32'($urandom_range(0, 13));
            endcase
            i_learn_mac     = 48'({$urandom(), $urandom()});
            i_arp_req_ready = ($urandom_range(0, 9) < 3);
            tick();
        end
        i_rst = 1'b1; i_seek_ip_valid = 1'b0; i_learn_valid = 1'b0; i_arp_req_ready = 1'b0;
        tick(); tick(); tick();

        i_seek_ip = 32'h0A00_0003; i_seek_ip_valid = 1'b1;
        tick();
        i_seek_ip_valid = 1'b0; i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        chk("midrst_vld0", 64'(o_seek_mac_valid), 64'd0);
        tick();
        chk("midrst_vld1", 64'(o_seek_mac_valid), 64'd0);
        chk("midrst_mac", 64'(o_seek_mac), 64'd0);
        chk("midrst_arp", 64'(o_arp_req_valid), 64'd0);
        chk("midrst_cnt", 64'(o_entry_cnt), 64'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
